// File: rtl/mad_result_scheduler_if.sv
// Result-path bundle between the block-matching engine and the result scheduler.
// The master modport drives search control and candidates; the slave modport returns the serial result.
interface mad_result_scheduler_if #(
  parameter int COORD_W = 8,
  parameter int MAD_W   = 12
);
  logic               block_start;
  logic               cand_valid;
  logic [COORD_W-1:0] coordinate;
  logic [MAD_W-1:0]   mad;
  logic               block_end;
  logic               serialport;
  logic               busy;
  logic               overrun;

  modport master (
    output block_start, cand_valid, coordinate, mad, block_end,
    input  serialport, busy, overrun
  );

  modport slave (
    input  block_start, cand_valid, coordinate, mad, block_end,
    output serialport, busy, overrun
  );
endinterface

// File: rtl/mad_result_scheduler.sv
// Tracks the minimum-MAD candidate of a search and sends {coordinate, mad} as a framed serial word.
// Optional macro PARITY_EN inserts an even-parity bit between the last data bit and the stop bit.
module mad_result_scheduler #(
  parameter int COORD_W      = 8,
  parameter int MAD_W        = 12,
  parameter int CLKS_PER_BIT = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  mad_result_scheduler_if.slave bus
);

  localparam int DATA_W = COORD_W + MAD_W;
`ifdef PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int FRAME_W = DATA_W + 2 + PAR_W;
  localparam int BIT_CW  = $clog2(FRAME_W);
  localparam int CLK_CW  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BIT_CW-1:0] LAST_BIT = BIT_CW'(FRAME_W - 1);
  localparam logic [CLK_CW-1:0] LAST_CLK = CLK_CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, SEARCH, SHIFT} state_t;

  state_t             state;
  logic [COORD_W-1:0] best_coord;
  logic [MAD_W-1:0]   best_mad;
  logic [FRAME_W-2:0] shift_reg;
  logic [BIT_CW-1:0]  bit_cnt;
  logic [CLK_CW-1:0]  clk_cnt;
  logic               serial_q;
  logic               busy_q;
  logic               overrun_q;

  logic               cand_better;
  logic [DATA_W-1:0]  final_word;
  logic [FRAME_W-1:0] frame;

  // A candidate arriving together with block_end still competes for the final word.
  always_comb begin
    cand_better = bus.cand_valid && (bus.mad < best_mad);
    final_word  = cand_better ? {bus.coordinate, bus.mad} : {best_coord, best_mad};
`ifdef PARITY_EN
    frame = {1'b0, final_word, ^final_word, 1'b1};
`else
    frame = {1'b0, final_word, 1'b1};
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      best_coord <= '0;
      best_mad   <= '1;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      clk_cnt    <= '0;
      serial_q   <= 1'b1;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.block_start) begin
            best_coord <= '0;
            best_mad   <= '1;
            state      <= SEARCH;
          end
        end
        SEARCH: begin
          if (bus.block_start) begin
            best_coord <= '0;
            best_mad   <= '1;
          end else if (bus.block_end) begin
            {best_coord, best_mad} <= final_word;
            serial_q  <= frame[FRAME_W-1];
            shift_reg <= frame[FRAME_W-2:0];
            bit_cnt   <= '0;
            clk_cnt   <= '0;
            busy_q    <= 1'b1;
            state     <= SHIFT;
          end else if (cand_better) begin
            best_coord <= bus.coordinate;
            best_mad   <= bus.mad;
          end
        end
        SHIFT: begin
          overrun_q <= bus.block_start | bus.block_end;
          if (clk_cnt == LAST_CLK) begin
            clk_cnt <= '0;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt  <= '0;
              serial_q <= 1'b1;
              busy_q   <= 1'b0;
              state    <= IDLE;
            end else begin
              bit_cnt   <= bit_cnt + 1'b1;
              serial_q  <= shift_reg[FRAME_W-2];
              shift_reg <= {shift_reg[FRAME_W-3:0], 1'b0};
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.serialport = serial_q;
  assign bus.busy       = busy_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_mad_result_scheduler.sv
// Scoreboard bench for mad_result_scheduler: directed searches push expected words, a monitor decodes frames.
// Builds with or without PARITY_EN.
module tb_mad_result_scheduler;

  localparam int COORD_W = 8;
  localparam int MAD_W   = 12;
  localparam int CPB     = 4;
`ifdef PARITY_EN
  localparam int FRAME_W = 23;
`else
  localparam int FRAME_W = 22;
`endif
  localparam int FRAME_CYC = FRAME_W * CPB;

  typedef struct packed {
    logic [19:0] word;
    logic        parity;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   ovr_seen = 0;
  logic [FRAME_CYC-1:0] samples;
  logic [19:0] rx_word;
  logic aborted, consistent, busy_ok;
  exp_t cur;

  always #5 clk = ~clk;

  mad_result_scheduler_if #(.COORD_W(COORD_W), .MAD_W(MAD_W)) bus ();

  mad_result_scheduler #(
    .COORD_W(COORD_W),
    .MAD_W(MAD_W),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] required);
    vectors++;
    if (actual !== required) begin
      miscompares++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, required);
    end
  endtask

  task automatic apply_stimulus(input logic bs, input logic cv, input logic [7:0] co,
                                input logic [11:0] md, input logic be);
    bus.block_start = bs;
    bus.cand_valid  = cv;
    bus.coordinate  = co;
    bus.mad         = md;
    bus.block_end   = be;
    @(posedge clk);
    #1;
    bus.block_start = 1'b0;
    bus.cand_valid  = 1'b0;
    bus.coordinate  = '0;
    bus.mad         = '0;
    bus.block_end   = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [19:0] w, input logic p);
    exp_t e;
    e.word   = w;
    e.parity = p;
    exp_q.push_back(e);
  endtask

  // Ends a search and checks the start bit is already on the line one cycle later.
  task automatic end_search(input logic cv, input logic [7:0] co, input logic [11:0] md);
    apply_stimulus(1'b0, cv, co, md, 1'b1);
    check_output("start_latency_serial", bus.serialport, 0);
    check_output("start_latency_busy", bus.busy, 1);
  endtask

  initial begin : overrun_monitor
    forever begin
      @(negedge clk);
      if (rst_n && bus.overrun === 1'b1) ovr_seen++;
    end
  end

  initial begin : frame_monitor
    forever begin
      @(negedge clk);
      if (rst_n && bus.busy === 1'b1) begin
        aborted = 1'b0;
        busy_ok = 1'b1;
        for (int i = 0; i < FRAME_CYC; i++) begin
          if (i > 0) @(negedge clk);
          if (!rst_n) begin
            aborted = 1'b1;
            break;
          end
          samples[i] = bus.serialport;
          if (bus.busy !== 1'b1) busy_ok = 1'b0;
        end
        if (!aborted) begin
          @(negedge clk);
          if (!rst_n) aborted = 1'b1;
        end
        if (!aborted) begin
          consistent = 1'b1;
          for (int b = 0; b < FRAME_W; b++)
            for (int k = 1; k < CPB; k++)
              if (samples[b*CPB+k] !== samples[b*CPB]) consistent = 1'b0;
          for (int b = 0; b < 20; b++) rx_word[19-b] = samples[(b+1)*CPB];
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL unexpected_frame: actual word=%05h required no frame", rx_word);
          end else begin
            cur = exp_q.pop_front();
            check_output("frame_start_bit", samples[0], 0);
            check_output("frame_word", rx_word, cur.word);
`ifdef PARITY_EN
            check_output("frame_parity", samples[21*CPB], cur.parity);
`endif
            check_output("frame_stop_bit", samples[(FRAME_W-1)*CPB], 1);
            check_output("frame_bit_hold", consistent, 1);
            check_output("frame_busy_span", busy_ok, 1);
            check_output("frame_end_busy", bus.busy, 0);
            check_output("frame_end_serial", bus.serialport, 1);
          end
        end
      end
    end
  end

  initial begin : stimulus
    bus.block_start = 1'b0;
    bus.cand_valid  = 1'b0;
    bus.coordinate  = '0;
    bus.mad         = '0;
    bus.block_end   = 1'b0;
    rst_n = 1'b0;
    idle_cycles(3);
    check_output("reset_serial", bus.serialport, 1);
    check_output("reset_busy", bus.busy, 0);
    check_output("reset_overrun", bus.overrun, 0);
    rst_n = 1'b1;
    idle_cycles(2);

    apply_stimulus(1'b0, 1'b1, 8'h77, 12'h001, 1'b1);
    idle_cycles(FRAME_CYC + 4);
    check_output("idle_block_end_busy", bus.busy, 0);
    check_output("idle_block_end_serial", bus.serialport, 1);

    // 20'h340A5 holds seven ones, so its even-parity bit is 1.
    apply_stimulus(1'b1, 1'b0, 8'h00, 12'h000, 1'b0);
    apply_stimulus(1'b0, 1'b1, 8'h12, 12'h300, 1'b0);
    apply_stimulus(1'b0, 1'b1, 8'h34, 12'h0A5, 1'b0);
    apply_stimulus(1'b0, 1'b1, 8'h56, 12'h200, 1'b0);
    push_exp(20'h340A5, 1'b1);
    end_search(1'b0, 8'h00, 12'h000);
    idle_cycles(FRAME_CYC + 4);

    apply_stimulus(1'b1, 1'b0, 8'h00, 12'h000, 1'b0);
    apply_stimulus(1'b0, 1'b1, 8'h10, 12'h050, 1'b0);
    apply_stimulus(1'b0, 1'b1, 8'h20, 12'h050, 1'b0);
    push_exp(20'h30040, 1'b1);
    end_search(1'b1, 8'h30, 12'h040);
    idle_cycles(FRAME_CYC + 4);

    apply_stimulus(1'b1, 1'b0, 8'h00, 12'h000, 1'b0);
    apply_stimulus(1'b0, 1'b1, 8'h10, 12'h050, 1'b0);
    apply_stimulus(1'b0, 1'b1, 8'h20, 12'h050, 1'b0);
    push_exp(20'h10050, 1'b1);
    end_search(1'b0, 8'h00, 12'h000);
    idle_cycles(FRAME_CYC + 4);

    apply_stimulus(1'b1, 1'b0, 8'h00, 12'h000, 1'b0);
    apply_stimulus(1'b0, 1'b1, 8'hAB, 12'hFFF, 1'b0);
    push_exp(20'h00FFF, 1'b0);
    end_search(1'b0, 8'h00, 12'h000);
    idle_cycles(FRAME_CYC + 4);

    apply_stimulus(1'b1, 1'b0, 8'h00, 12'h000, 1'b0);
    apply_stimulus(1'b0, 1'b1, 8'h05, 12'h001, 1'b0);
    apply_stimulus(1'b1, 1'b1, 8'h07, 12'h000, 1'b0);
    apply_stimulus(1'b0, 1'b1, 8'h09, 12'h100, 1'b0);
    push_exp(20'h09100, 1'b1);
    end_search(1'b0, 8'h00, 12'h000);
    idle_cycles(FRAME_CYC + 4);

    apply_stimulus(1'b1, 1'b0, 8'h00, 12'h000, 1'b0);
    apply_stimulus(1'b0, 1'b1, 8'h34, 12'h0A5, 1'b0);
    push_exp(20'h340A5, 1'b1);
    end_search(1'b0, 8'h00, 12'h000);
    idle_cycles(20);
    apply_stimulus(1'b1, 1'b1, 8'h01, 12'h000, 1'b0);
    check_output("overrun_start_pulse", bus.overrun, 1);
    idle_cycles(1);
    check_output("overrun_start_clear", bus.overrun, 0);
    idle_cycles(10);
    apply_stimulus(1'b0, 1'b0, 8'h00, 12'h000, 1'b1);
    check_output("overrun_end_pulse", bus.overrun, 1);
    idle_cycles(1);
    check_output("overrun_end_clear", bus.overrun, 0);
    idle_cycles(FRAME_CYC);
    apply_stimulus(1'b0, 1'b0, 8'h00, 12'h000, 1'b1);
    idle_cycles(FRAME_CYC + 4);
    check_output("post_overrun_idle_busy", bus.busy, 0);

    apply_stimulus(1'b1, 1'b0, 8'h00, 12'h000, 1'b0);
    apply_stimulus(1'b0, 1'b1, 8'h01, 12'h001, 1'b0);
    end_search(1'b0, 8'h00, 12'h000);
    idle_cycles(30);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async_reset_serial", bus.serialport, 1);
    check_output("async_reset_busy", bus.busy, 0);
    idle_cycles(2);
    rst_n = 1'b1;
    idle_cycles(1);
    apply_stimulus(1'b0, 1'b0, 8'h00, 12'h000, 1'b1);
    idle_cycles(FRAME_CYC + 4);
    check_output("post_reset_idle_busy", bus.busy, 0);

    check_output("queue_drained", exp_q.size(), 0);
    check_output("overrun_count", ovr_seen, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
